// File: rtl/ee354_gcd_scheduler_pkg.sv
// rtl/ee354_gcd_scheduler_pkg.sv - shared types and constants for the GCD scheduler
//
// Purpose : FSM state encoding, datapath width, requester-index width and the
//           round-robin pointer advance helper shared by the scheduler files.
// Ports   : none (package).

package ee354_gcd_scheduler_pkg;

    // Operand / result width of the shared GCD core.
    localparam int DW    = 8;

    // Requester index width; wide enough for the largest supported NREQ (8).
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        ST_ARB   = 3'd0,
        ST_CLR   = 3'd1,
        ST_STRT  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4,
        ST_DLVR  = 3'd5,
        ST_ABORT = 3'd6
    } state_t;

    // Pointer to the requester just after idx, wrapping at nreq.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx,
                                                  input int              nreq);
        if (int'(idx) + 1 >= nreq) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/ee354_gcd_scheduler_rr_arbiter.sv
// rtl/ee354_gcd_scheduler_rr_arbiter.sv - combinational round-robin request picker
//
// Purpose : Picks the first asserted request at or after the pointer, wrapping
//           modulo NREQ. Purely combinational; the scheduler latches the result.
// Ports   : i_req  [NREQ-1:0]  request vector
//           i_ptr  [IDX_W-1:0] round-robin start position (0..NREQ-1)
//           o_gnt  [NREQ-1:0]  one-hot winner, 0 when no request
//           o_idx  [IDX_W-1:0] binary index of the winner, 0 when no request
//           o_any              at least one request present

module ee354_gcd_scheduler_rr_arbiter
    import ee354_gcd_scheduler_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [NREQ-1:0] w_rot;
    logic [IDX_W:0]  w_sum;
    logic [IDX_W:0]  w_pos;

    // Rotate the requests so the pointer position lands at bit 0; the first
    // set bit of the rotated vector is then the round-robin winner.
    assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_sum = '0;
        w_pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
                // Undo the rotation: position = ptr + k modulo NREQ.
                w_pos = (w_sum >= (IDX_W+1)'(NREQ)) ? w_sum - (IDX_W+1)'(NREQ) : w_sum;
                o_idx = w_pos[IDX_W-1:0];
            end
        end
    end

    assign o_gnt = o_any ? ({{(NREQ-1){1'b0}}, 1'b1} << o_idx) : '0;

endmodule

// File: rtl/ee354_gcd_scheduler.sv
// rtl/ee354_gcd_scheduler.sv - round-robin scheduler sharing one ee354_GCD core
//
// Purpose : Arbitrates NREQ requesters onto a single GCD core. Each job clears
//           the core, loads operands, pulses Start, waits for q_Done, captures
//           the result, pulses Ack and strobes the result back to the owner.
//           Zero operands are answered directly (gcd = A|B); a watchdog aborts
//           jobs that sit in WAIT for TIMEOUT enabled cycles.
// Ports   : i_Clk, i_Reset (sync, active low), i_SCEN (single-clock enable)
//           i_Req[NREQ], i_Ain_bus/i_Bin_bus[8*NREQ] packed operands
//           o_Gnt[NREQ] owner, o_Rsp_valid[NREQ] result strobe,
//           o_Rsp_gcd/o_Rsp_icount[8], o_Rsp_timeout
//           o_Core_Reset/Start/Ack, o_Core_Ain/Bin[8], o_Core_SCEN to the core
//           i_Core_q_Done, i_Core_AB_GCD[8], i_Core_i_count[8] from the core

module ee354_gcd_scheduler
    import ee354_gcd_scheduler_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_SCEN,
    input  logic [NREQ-1:0]    i_Req,
    input  logic [8*NREQ-1:0]  i_Ain_bus,
    input  logic [8*NREQ-1:0]  i_Bin_bus,
    output logic [NREQ-1:0]    o_Gnt,
    output logic [NREQ-1:0]    o_Rsp_valid,
    output logic [7:0]         o_Rsp_gcd,
    output logic [7:0]         o_Rsp_icount,
    output logic               o_Rsp_timeout,
    output logic               o_Core_Reset,
    output logic               o_Core_Start,
    output logic               o_Core_Ack,
    output logic [7:0]         o_Core_Ain,
    output logic [7:0]         o_Core_Bin,
    output logic               o_Core_SCEN,
    input  logic               i_Core_q_Done,
    input  logic [7:0]         i_Core_AB_GCD,
    input  logic [7:0]         i_Core_i_count
);

    // Last watchdog value allowed in WAIT; reaching it without Done aborts.
    localparam logic [DW-1:0] WD_LAST = DW'(TIMEOUT - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [DW-1:0]    r_ain;
    logic [DW-1:0]    r_bin;
    logic [DW-1:0]    r_gcd;
    logic [DW-1:0]    r_icount;
    logic [DW-1:0]    r_wdog;

    logic [NREQ-1:0]  w_arb_gnt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic [DW-1:0]    w_sel_a;
    logic [DW-1:0]    w_sel_b;
    logic [NREQ-1:0]  w_own;
    logic             w_rsp_state;

    ee354_gcd_scheduler_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req (i_Req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Operands of the arbitration winner, unpacked from the 8-bit lanes.
    assign w_sel_a = DW'(i_Ain_bus >> {w_arb_idx, 3'b000});
    assign w_sel_b = DW'(i_Bin_bus >> {w_arb_idx, 3'b000});

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            r_state  <= ST_ARB;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_ain    <= '0;
            r_bin    <= '0;
            r_gcd    <= '0;
            r_icount <= '0;
            r_wdog   <= '0;
        end else if (i_SCEN) begin
            case (r_state)
                ST_ARB: begin
                    if (w_arb_any) begin
                        r_idx <= w_arb_idx;
                        r_ain <= w_sel_a;
                        r_bin <= w_sel_b;
                        // gcd(x,0) = x, so a zero operand never needs the core.
                        if (w_sel_a == '0 || w_sel_b == '0) begin
                            r_gcd    <= w_sel_a | w_sel_b;
                            r_icount <= '0;
                            r_state  <= ST_DLVR;
                        end else begin
                            r_state  <= ST_CLR;
                        end
                    end
                end
                ST_CLR: begin
                    r_state <= ST_STRT;
                end
                ST_STRT: begin
                    r_wdog  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wdog <= r_wdog + DW'(1);
                    // Done wins over the watchdog when both happen together.
                    if (i_Core_q_Done) begin
                        r_gcd    <= i_Core_AB_GCD;
                        r_icount <= i_Core_i_count;
                        r_state  <= ST_ACK;
                    end else if (r_wdog == WD_LAST) begin
                        r_gcd    <= '0;
                        r_icount <= '0;
                        r_state  <= ST_ABORT;
                    end
                end
                ST_ACK, ST_DLVR, ST_ABORT: begin
                    r_ptr   <= next_ptr(r_idx, NREQ);
                    r_state <= ST_ARB;
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    // Moore decode: everything below depends only on registered state, so
    // holding SCEN low freezes every output along with the core.
    assign w_own       = {{(NREQ-1){1'b0}}, 1'b1} << r_idx;
    assign w_rsp_state = (r_state == ST_ACK) || (r_state == ST_DLVR) || (r_state == ST_ABORT);

    assign o_Gnt         = (r_state != ST_ARB) ? w_own : '0;
    assign o_Rsp_valid   = w_rsp_state ? w_own : '0;
    assign o_Rsp_gcd     = r_gcd;
    assign o_Rsp_icount  = r_icount;
    assign o_Rsp_timeout = (r_state == ST_ABORT);

    // The core is held in reset with us, cleared before each job and
    // cleared again after an abort so a hung core is recovered.
    assign o_Core_Reset  = ~i_Reset | (r_state == ST_CLR) | (r_state == ST_ABORT);
    assign o_Core_Start  = (r_state == ST_STRT);
    assign o_Core_Ack    = (r_state == ST_ACK);
    assign o_Core_Ain    = r_ain;
    assign o_Core_Bin    = r_bin;
    assign o_Core_SCEN   = i_SCEN;

endmodule
